// File: rtl/hweval_pkg.sv
// Shared types and helpers for the on-board arithmetic evaluation harnesses.
// Operand shaping works on 64-bit lanes so it is independent of DATA_W.
package hweval_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_GEN_A, S_GEN_B, S_GEN_M, S_START, S_WAIT, S_FOLD, S_DONE, S_ERR
  } state_t;

  // Galois mask for x^64 + x^63 + x^61 + x^60 + 1 (right-shifting form)
  localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DEFAULT_SEED = 64'hACE1_0000_0000_0001;

  function automatic logic [63:0] set_msb64(input logic [63:0] w);
    return {1'b1, w[62:0]};
  endfunction

  function automatic logic [63:0] clr_msb64(input logic [63:0] w);
    return {1'b0, w[62:0]};
  endfunction

  function automatic logic [63:0] set_lsb64(input logic [63:0] w);
    return {w[63:1], 1'b1};
  endfunction

endpackage

// File: rtl/lfsr64.sv
// 64-bit Galois LFSR with synchronous load; steps only when asked.
// Reset and load both return it to SEED so campaigns are repeatable.
module lfsr64 import hweval_pkg::*; #(
  parameter logic [63:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  output logic [63:0] value
);

  always_ff @(posedge clk) begin
    if (reset || load)
      value <= SEED;
    else if (step)
      value <= {1'b0, value[63:1]} ^ (value[0] ? LFSR_TAPS : 64'h0);
  end

endmodule

// File: rtl/hweval_mont_harness.sv
// Evaluation harness: drives NUM_RUNS start/done transactions on an attached
// core with LFSR operands and compresses the results into a MISR signature.
//
// state   | meaning
// IDLE    | waiting for go
// GEN_A/B | capture operand a / b (msb cleared)
// GEN_M   | capture modulus m (msb and lsb set), arm start pulse
// START   | dut_start high, latency counter cleared
// WAIT    | count until dut_done or timeout
// FOLD    | fold captured result into signature, update stats
// DONE    | campaign complete, data_ok tracks expected_sig
// ERR     | transaction timed out
module hweval_mont_harness import hweval_pkg::*; #(
  parameter int          DATA_W   = 1024,
  parameter int          NUM_RUNS = 16,
  parameter int          TIMEOUT  = 4095,
  parameter int          CNT_W    = 16,
  parameter logic [63:0] SEED     = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [DATA_W-1:0] expected_sig,
  output logic              dut_start,
  output logic [DATA_W-1:0] dut_a,
  output logic [DATA_W-1:0] dut_b,
  output logic [DATA_W-1:0] dut_m,
  input  logic [DATA_W-1:0] dut_result,
  input  logic              dut_done,
  output logic              busy,
  output logic              finished,
  output logic              data_ok,
  output logic              timeout_err,
  output logic [DATA_W-1:0] signature,
  output logic [CNT_W-1:0]  max_latency,
  output logic [CNT_W-1:0]  runs_done
);

  localparam int             NWORDS    = DATA_W / 64;
  localparam logic [CNT_W-1:0] RUNS_LAST = CNT_W'(NUM_RUNS - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  state_t              state;
  logic [CNT_W-1:0]    lat_cnt;
  logic [CNT_W-1:0]    lat_q;
  logic [DATA_W-1:0]   result_q;
  logic [63:0]         lfsr_value;
  logic [DATA_W-1:0]   raw;
  logic [DATA_W-1:0]   op_ab;
  logic [DATA_W-1:0]   op_m;
  logic [DATA_W-1:0]   sig_next;
  logic                idle_like;
  logic                lfsr_load;
  logic                lfsr_step;

  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign lfsr_load = idle_like && go;
  assign lfsr_step = (state == S_GEN_A) || (state == S_GEN_B) || (state == S_GEN_M);

  lfsr64 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  assign raw = {NWORDS{lfsr_value}};

  // Shaping keeps a, b below m and m odd, as a Montgomery core requires.
  always_comb begin
    op_ab = raw;
    op_ab[DATA_W-1 -: 64] = clr_msb64(raw[DATA_W-1 -: 64]);
    op_m = raw;
    op_m[DATA_W-1 -: 64] = set_msb64(raw[DATA_W-1 -: 64]);
    op_m[63:0] = set_lsb64(op_m[63:0]);
  end

  assign sig_next = {signature[DATA_W-2:0], signature[DATA_W-1]} ^ result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      dut_start   <= 1'b0;
      dut_a       <= '0;
      dut_b       <= '0;
      dut_m       <= '0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      data_ok     <= 1'b0;
      timeout_err <= 1'b0;
      signature   <= '0;
      max_latency <= '0;
      runs_done   <= '0;
      lat_cnt     <= '0;
      lat_q       <= '0;
      result_q    <= '0;
    end else begin
      dut_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (state == S_DONE)
            data_ok <= (signature == expected_sig);
          if (go) begin
            state       <= S_GEN_A;
            signature   <= '0;
            runs_done   <= '0;
            max_latency <= '0;
            timeout_err <= 1'b0;
            finished    <= 1'b0;
            data_ok     <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_GEN_A: begin
          dut_a <= op_ab;
          state <= S_GEN_B;
        end
        S_GEN_B: begin
          dut_b <= op_ab;
          state <= S_GEN_M;
        end
        S_GEN_M: begin
          dut_m     <= op_m;
          dut_start <= 1'b1;
          state     <= S_START;
        end
        S_START: begin
          lat_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt + 1'b1;
          // done wins over a coincident timeout
          if (dut_done) begin
            lat_q    <= lat_cnt + 1'b1;
            result_q <= dut_result;
            state    <= S_FOLD;
          end else if (lat_cnt == TO_LAST) begin
            state       <= S_ERR;
            busy        <= 1'b0;
            finished    <= 1'b1;
            timeout_err <= 1'b1;
            data_ok     <= 1'b0;
          end
        end
        S_FOLD: begin
          signature <= sig_next;
          runs_done <= runs_done + 1'b1;
          if (lat_q > max_latency)
            max_latency <= lat_q;
          if (runs_done == RUNS_LAST) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            finished <= 1'b1;
            data_ok  <= (sig_next == expected_sig);
          end else begin
            state <= S_GEN_A;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/hweval_mont_harness.md
Name: hweval_mont_harness

Overview:
- Self-checking on-board evaluation harness for the Montgomery multiplier and future start/done arithmetic cores.
- Generates pseudo-random operands a, b, m from an LFSR and runs NUM_RUNS start/done transactions on the attached core.
- Compresses every result into a MISR signature, records the worst-case latency and flags timeouts.
- Raises data_ok when the final signature matches the expected value; intended as the top of a board-level evaluation build.

Parameters:
- DATA_W, 1024, operand/result width; multiple of 64, minimum 128.
- NUM_RUNS, 16, transactions per campaign, 1 to 2^CNT_W-1.
- TIMEOUT, 4095, maximum WAIT cycles per transaction before error; must be < 2^CNT_W.
- CNT_W, 16, width of counters and statistics outputs.
- SEED, 64'hACE1_0000_0000_0001, LFSR reset/restart value, non-zero.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- go  in  1  campaign start pulse; ignored while busy.
- expected_sig  in  DATA_W  golden signature.
- dut_start  out  1  one-cycle start pulse to the core.
- dut_a, dut_b, dut_m  out  DATA_W each  operands, held stable from dut_start until dut_done.
- dut_result  in  DATA_W  core result, valid when dut_done=1.
- dut_done  in  1  core completion strobe.
- busy  out  1  campaign in progress.
- finished  out  1  campaign ended (pass, fail or timeout); sticky until go or reset.
- data_ok  out  1  finished, no timeout, and signature==expected_sig.
- timeout_err  out  1  a transaction exceeded TIMEOUT.
- signature  out  DATA_W  MISR state.
- max_latency  out  CNT_W  worst start-to-done cycle count.
- runs_done  out  CNT_W  completed transactions.

Behaviour:
- Reset (sync, active-high): all outputs and registers are 0, the LFSR loads SEED and the FSM goes to IDLE.
  - This applies equally mid-campaign: an in-flight transaction is abandoned and any later dut_done is ignored.
- LFSR: 64-bit Galois, taps 64,63,61,60.
  - It steps exactly once per GEN_* state.
  - The raw operand for a GEN_* state is the current LFSR value replicated DATA_W/64 times.
  - The LFSR is reloaded with SEED on every accepted go, so campaigns are repeatable.
- Operand shaping guarantees a,b < m, with m odd:
  - dut_m: bit DATA_W-1 forced to 1 and bit 0 forced to 1.
  - dut_a and dut_b: bit DATA_W-1 forced to 0.
- FSM states: IDLE, GEN_A, GEN_B, GEN_M, START, WAIT, FOLD, DONE, ERR.
  - IDLE: on go -> GEN_A. Clear signature, runs_done, max_latency, timeout_err and finished; reload the LFSR; set busy=1.
  - GEN_A -> GEN_B -> GEN_M: each captures its operand (one cycle each).
  - GEN_M -> START.
  - START: dut_start=1 for exactly this cycle; latency counter <= 0; -> WAIT.
  - WAIT: counter increments every cycle.
    - If dut_done: latency = counter+1; -> FOLD.
    - Else if counter+1 == TIMEOUT: -> ERR.
    - If dut_done and the timeout condition coincide, done wins.
  - FOLD: signature <= rotl1(signature) ^ dut_result, using the result captured in WAIT. Then:
    - runs_done++;
    - max_latency = max(max_latency, latency);
    - if runs_done+1 == NUM_RUNS -> DONE, else -> GEN_A.
  - DONE: busy=0, finished=1; data_ok registered as (signature==expected_sig). On go -> same restart as IDLE.
  - ERR: busy=0, finished=1, timeout_err=1, data_ok=0. On go -> same restart.
- Ignored inputs:
  - dut_done outside WAIT.
  - go while busy.
- data_ok is 0 whenever finished=0. It stays re-evaluated against expected_sig while in DONE.
- Latency per transaction is cycles from the dut_start cycle (exclusive) to the dut_done cycle (inclusive); minimum 1.
- Transaction overhead: 5 cycles (GEN_A, GEN_B, GEN_M, START, FOLD) plus core latency.

Decomposition:
- Package hweval_pkg:
  - FSM state enum;
  - LFSR tap constant and default SEED;
  - operand mask helpers (set/clear MSB, set LSB).
- Sub-module lfsr64 (load, step, value), reusable by later eval harnesses.
- The MISR stays inline.

Test Plan:
- Reset: hold reset 3 cycles -> all outputs 0, dut_start 0. Release with go=0 -> stays IDLE, busy=0 indefinitely.
- Nominal: DATA_W=128, NUM_RUNS=2, stub core (result = a^b^m after 5 cycles), expected_sig from bench model.
  - First dut_m has bit127=1 and bit0=1; first dut_a/dut_b have bit127=0.
  - Exactly 2 dut_start pulses.
  - End state: runs_done=2, max_latency=5, finished=1, data_ok=1, timeout_err=0.
  - Campaign length 2*(5+5)=20 cycles after go.
- Mismatch: same as Nominal but expected_sig = golden ^ 1 -> finished=1, data_ok=0, timeout_err=0.
- Timeout: TIMEOUT=20, stub never asserts done -> ERR after 20 WAIT cycles, timeout_err=1, finished=1, data_ok=0, runs_done=0. A late dut_done afterwards changes nothing.
- Reset mid-run: assert reset during WAIT of run 1 -> next cycle busy=0, signature=0, runs_done=0. Issue go -> signature identical to Nominal (repeatability).
- Variable latency and ignored inputs: stub latencies 3 then 9 -> max_latency=9.
  - go pulsed during WAIT -> ignored, no restart.
  - dut_done pulsed during GEN_B -> ignored; runs_done still ends at 2.
